ascon_perm_ctrl: RTL and testbench
==================================

Name: ascon_perm_ctrl

Overview:
Iterative sequencer for the ASCON permutation p^a.
- Holds the 320-bit state (x0..x4) and runs one round per clock through an external combinational round datapath: constant addition, substitution layer, linear layer.
- Generates the current round index i and the constant index I = 12 - a + i consumed by the constant-addition stage.
- Sits between the mode-level controller (init/AD/encrypt/final phases, issuing p^12 or p^6/p^8) and the round datapath.

Parameters:
MAX_ROUNDS, 12, upper bound on a; requested a > MAX_ROUNDS is clamped to MAX_ROUNDS.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a permutation run; accepted only when ready=1
rounds_a  input  4  number of rounds a (valid 0..12), sampled on accept
state_in  input  320  initial state {x0,x1,x2,x3,x4}, x0 in [319:256], sampled on accept
ready  output  1  1 in IDLE only
busy  output  1  1 in RUN
rnd_i  output  4  current round index i (0..a-1) during RUN
rnd_idx  output  4  constant index I = 12 - a + i during RUN
dp_state_out  output  320  current state register, fed to the round datapath
dp_state_in  input  320  round datapath result (state after one full round)
state_out  output  320  final state; equals the state register and is valid while done=1
done  output  1  one-cycle completion pulse

Behaviour:
- Reset values:
  - FSM = IDLE, ready = 1, busy = 0, done = 0.
  - rnd_i = 0, rnd_idx = 0.
  - State register = 0, so dp_state_out and state_out = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1, load state_reg <= state_in, a_reg <= min(rounds_a, MAX_ROUNDS), i <= 0.
  - Next state is RUN if a_reg != 0, else DONE.
- RUN, every cycle:
  - state_reg <= dp_state_in.
  - If i == a_reg-1, go to DONE; otherwise i <= i+1.
- DONE:
  - done = 1 for exactly one cycle, state_out valid.
  - Next state is IDLE unconditionally.
- Latency: accept edge at cycle 0 → a RUN cycles (1..a) → done high in cycle a+1. For a=0, done is high in cycle 1 with state_out == state_in.
- rnd_idx arithmetic:
  - Computed in 4 bits as 12 - a_reg + i; never exceeds 11 for legal a.
  - Outside RUN, rnd_i = 0 and rnd_idx = 0.
- Handshake and ordering:
  - start while ready=0 (RUN or DONE) is ignored; there is no queueing.
  - New inputs are accepted at the earliest in the IDLE cycle following DONE.
  - rounds_a and state_in are don't-care except on the accept cycle.
- state_reg changes only on accept and in RUN; it holds its value in DONE and IDLE. state_out therefore stays stable after done until the next accept.
- Reset mid-run: rst dominates every other input. It returns the block to IDLE with reset values; no done pulse is issued for the aborted run.
- Simultaneous rst and start: rst wins and start is not accepted.

Optional Feature:
ASCON_PERM_ABORT_EN
- With the macro defined, an extra input abort (1 bit) exists.
  - abort=1 in RUN or DONE forces IDLE on the next edge.
  - The next-cycle done pulse is suppressed; state_reg holds its value; rnd_i and rnd_idx return to 0.
  - abort in IDLE has priority over start: the request is not accepted.
- Without the macro, no abort port exists and runs always complete.

Test Plan:
- Reset with rst=1 for 2 cycles → ready=1, busy=0, done=0, state_out=0, rnd_idx=0.
- start, a=12, state_in = ASCON-128 IV/key/nonce init state (IV 0x80400c0600000000); round datapath model attached → rnd_idx steps 0,1,…,11 in cycles 1..12; done only in cycle 13; state_out matches the reference p^12 vector.
- start, a=6 → rnd_i 0..5 paired with rnd_idx 6..11; done in cycle 7; busy high for exactly 6 cycles.
- start, a=0, state_in = 0x0123…CDEF pattern → no RUN cycles; done in cycle 1; state_out == state_in. Separately, a=15 → clamped: exactly 12 rounds, rnd_idx 0..11.
- start re-asserted throughout a 6-round run with different state_in → ignored; result is unaffected. Next accept happens only in the IDLE cycle after done.
- rst pulsed at round i=4 of an a=12 run → IDLE next cycle, no done, state_out=0. With ASCON_PERM_ABORT_EN, abort at i=4 → IDLE, no done, state held at its round-4 value, ready=1.

Source files
------------

// File: rtl/ascon_perm_ctrl.sv
// Iterative ASCON p^a sequencer: holds the 320-bit state and steps one round per clock
// through an external round datapath. Optional abort input enabled by `define ASCON_PERM_ABORT_EN.
module ascon_perm_ctrl #(
    parameter int MAX_ROUNDS = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef ASCON_PERM_ABORT_EN
    input  logic         abort,
`endif
    input  logic [3:0]   rounds_a,
    input  logic [319:0] state_in,
    output logic         ready,
    output logic         busy,
    output logic [3:0]   rnd_i,
    output logic [3:0]   rnd_idx,
    output logic [319:0] dp_state_out,
    input  logic [319:0] dp_state_in,
    output logic [319:0] state_out,
    output logic         done
);

    localparam logic [3:0] MAX_A = 4'(MAX_ROUNDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t           fsm, fsm_nxt;
    logic [319:0]   state_reg;
    logic [3:0]     a_reg;
    logic [3:0]     i_reg;
    logic [3:0]     a_clamped;
    logic           load;
    logic           step;
    logic           last_round;
    logic           abort_req;

`ifdef ASCON_PERM_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign a_clamped  = (rounds_a > MAX_A) ? MAX_A : rounds_a;
    assign last_round = (i_reg == a_reg - 4'd1);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) fsm <= IDLE;
        else     fsm <= fsm_nxt;
    end

    // NOTE: all combinational outputs get defaults first so no latch is inferred.
    always_comb begin
        fsm_nxt = fsm;
        load    = 1'b0;
        step    = 1'b0;
        case (fsm)
            IDLE: begin
                if (start && !abort_req) begin
                    load    = 1'b1;
                    fsm_nxt = (a_clamped != 4'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort_req) begin
                    fsm_nxt = IDLE;
                end else begin
                    step = 1'b1;
                    if (last_round) fsm_nxt = DONE;
                end
            end
            DONE:    fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    // State only moves on accept or during an un-aborted RUN cycle; held everywhere else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= '0;
            a_reg     <= '0;
            i_reg     <= '0;
        end else if (load) begin
            state_reg <= state_in;
            a_reg     <= a_clamped;
            i_reg     <= '0;
        end else if (step) begin
            state_reg <= dp_state_in;
            if (!last_round) i_reg <= i_reg + 4'd1;
        end
    end

    assign ready        = (fsm == IDLE);
    assign busy         = (fsm == RUN);
    assign done         = (fsm == DONE);
    assign rnd_i        = busy ? i_reg : 4'd0;
    assign rnd_idx      = busy ? (4'd12 - a_reg + i_reg) : 4'd0;
    assign dp_state_out = state_reg;
    assign state_out    = state_reg;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Self-checking bench for ascon_perm_ctrl with a behavioural ASCON round attached as datapath.
// Define ASCON_PERM_ABORT_EN for both files to exercise the abort input.
module tb_ascon_perm_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   rounds_a;
    logic [319:0] state_in;
    logic         ready, busy, done;
    logic [3:0]   rnd_i, rnd_idx;
    logic [319:0] dp_state_out, dp_state_in, state_out;
`ifdef ASCON_PERM_ABORT_EN
    logic         abort;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ascon_perm_ctrl #(.MAX_ROUNDS(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
`ifdef ASCON_PERM_ABORT_EN
        .abort        (abort),
`endif
        .rounds_a     (rounds_a),
        .state_in     (state_in),
        .ready        (ready),
        .busy         (busy),
        .rnd_i        (rnd_i),
        .rnd_idx      (rnd_idx),
        .dp_state_out (dp_state_out),
        .dp_state_in  (dp_state_in),
        .state_out    (state_out),
        .done         (done)
    );

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One full ASCON round: constant addition, bitsliced S-box, linear diffusion.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] idx);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        logic [3:0]  hi;
        {x0, x1, x2, x3, x4} = s;
        hi = 4'hf - idx;
        x2 = x2 ^ {56'd0, hi, idx};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    assign dp_state_in = ascon_round(dp_state_out, rnd_idx);

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int a, input int upto);
        logic [319:0] r = s;
        for (int k = 0; k < upto; k++) r = ascon_round(r, 4'(12 - a + k));
        return r;
    endfunction

    // Entered and left at a negedge in IDLE. With hold=1, start stays high with junk inputs.
    task automatic run_perm(input logic [3:0] a, input logic [319:0] st, input bit hold);
        int ae;
        logic [319:0] exp;
        ae  = (a > 4'd12) ? 12 : int'(a);
        exp = ref_perm(st, ae, ae);
        check("pre_ready", 320'(ready), 320'd1);
        start = 1'b1; rounds_a = a; state_in = st;
        @(negedge clk);
        for (int k = 1; k <= ae; k++) begin
            start = hold; rounds_a = 4'd3; state_in = ~st;
            check($sformatf("a%0d_busy_c%0d", a, k), 320'(busy), 320'd1);
            check($sformatf("a%0d_done_c%0d", a, k), 320'(done), 320'd0);
            check($sformatf("a%0d_rnd_i_c%0d", a, k), 320'(rnd_i), 320'(k - 1));
            check($sformatf("a%0d_rnd_idx_c%0d", a, k), 320'(rnd_idx), 320'(12 - ae + k - 1));
            @(negedge clk);
        end
        start = hold;
        check($sformatf("a%0d_done", a), 320'(done), 320'd1);
        check($sformatf("a%0d_busy_at_done", a), 320'(busy), 320'd0);
        check($sformatf("a%0d_ready_at_done", a), 320'(ready), 320'd0);
        check($sformatf("a%0d_state_out", a), state_out, exp);
        @(negedge clk);
        check($sformatf("a%0d_done_after", a), 320'(done), 320'd0);
        check($sformatf("a%0d_ready_after", a), 320'(ready), 320'd1);
        check($sformatf("a%0d_state_hold", a), state_out, exp);
        if (!hold) start = 1'b0;
    endtask

    // Starts an a=12 run and stops at the negedge of the cycle where rnd_i == 4.
    task automatic start_to_round4(input logic [319:0] st);
        start = 1'b1; rounds_a = 4'd12; state_in = st;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("r4_rnd_i", 320'(rnd_i), 320'd4);
        check("r4_state", state_out, ref_perm(st, 12, 4));
    endtask

    logic [319:0] init_st, pat_st;

    initial begin
        init_st = {64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0e0f,
                   64'h0001020304050607, 64'h08090a0b0c0d0e0f};
        pat_st  = {5{64'h0123456789abcdef}};
        rst = 1'b1; start = 1'b0; rounds_a = 4'd0; state_in = '0;
`ifdef ASCON_PERM_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 320'(ready), 320'd1);
        check("rst_busy", 320'(busy), 320'd0);
        check("rst_done", 320'(done), 320'd0);
        check("rst_state_out", state_out, 320'd0);
        check("rst_rnd_idx", 320'(rnd_idx), 320'd0);
        check("rst_rnd_i", 320'(rnd_i), 320'd0);
        // start together with rst must not be accepted
        start = 1'b1; rounds_a = 4'd6; state_in = pat_st;
        @(negedge clk);
        check("rst_start_ready", 320'(ready), 320'd1);
        check("rst_start_state", state_out, 320'd0);
        rst = 1'b0; start = 1'b0;

        run_perm(4'd12, init_st, 1'b0);
        run_perm(4'd6, pat_st, 1'b0);
        run_perm(4'd0, pat_st, 1'b0);
        run_perm(4'd15, init_st, 1'b0);

        // start held through a run: ignored until the IDLE cycle after done
        run_perm(4'd6, init_st, 1'b1);
        @(negedge clk);
        start = 1'b0;
        check("hold_reaccept_busy", 320'(busy), 320'd1);
        check("hold_reaccept_rnd_idx", 320'(rnd_idx), 320'd9);
        check("hold_reaccept_state", state_out, ~init_st);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // reset mid-run at i=4
        start_to_round4(init_st);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", 320'(ready), 320'd1);
        check("midrst_done", 320'(done), 320'd0);
        check("midrst_state", state_out, 320'd0);
        check("midrst_rnd_idx", 320'(rnd_idx), 320'd0);
        @(negedge clk);
        check("midrst_no_done", 320'(done), 320'd0);

`ifdef ASCON_PERM_ABORT_EN
        start_to_round4(pat_st);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ready", 320'(ready), 320'd1);
        check("abort_done", 320'(done), 320'd0);
        check("abort_rnd_i", 320'(rnd_i), 320'd0);
        check("abort_state", state_out, ref_perm(pat_st, 12, 4));
        @(negedge clk);
        check("abort_no_done", 320'(done), 320'd0);
        // abort beats start in IDLE
        abort = 1'b1; start = 1'b1; rounds_a = 4'd6; state_in = init_st;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_idle_ready", 320'(ready), 320'd1);
        check("abort_idle_state", state_out, ref_perm(pat_st, 12, 4));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
